// File: rtl/gshare_branch_predictor.sv
// Gshare branch predictor with a tagged BTB: combinational predict path for IF,
// resolved-branch training path from ID, plus branch/mispredict counters.
module gshare_branch_predictor #(
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         if_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [IDX_BITS-1:0] upd_index,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_pred_taken,
  input  logic [31:0]         upd_pred_target,
  output logic                mispredict,
  output logic [31:0]         num_branches,
  output logic [31:0]         num_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [IDX_BITS-1:0] ghr;
  logic                pred_hit;
  logic                upd_hit;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Predict path: asynchronous read, so a same-cycle update is seen one cycle later
  assign pred_index  = if_pc[IDX_BITS+1:2] ^ ghr;
  assign pred_hit    = valid_q[pred_index] && (tag_q[pred_index] == if_pc[31:IDX_BITS+2]);
  assign pred_taken  = pred_hit && ctr_q[pred_index][1];
  assign pred_target = pred_taken ? target_q[pred_index] : if_pc + 32'd4;

  assign upd_hit    = valid_q[upd_index] && (tag_q[upd_index] == upd_pc[31:IDX_BITS+2]);
  assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));

  // Control state: valid bits, counters, history and perf counters take reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      ghr             <= '0;
      num_branches    <= '0;
      num_mispredicts <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_index] <= sat_ctr(ctr_q[upd_index], upd_taken);
      end else if (upd_taken) begin
        valid_q[upd_index] <= 1'b1;
        ctr_q[upd_index]   <= 2'b10;
      end
      ghr             <= {ghr[IDX_BITS-2:0], upd_taken};
      num_branches    <= num_branches + 32'd1;
      num_mispredicts <= num_mispredicts + {31'd0, mispredict};
    end
  end

  // Data state: tag and target only matter behind a valid bit, so no reset.
  // On a hit the tag is unchanged, so writing it on every taken update is harmless.
  always_ff @(posedge clk) begin
    if (reset && upd_valid && upd_taken) begin
      tag_q[upd_index]    <= upd_pc[31:IDX_BITS+2];
      target_q[upd_index] <= upd_target;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench for gshare_branch_predictor (IDX_BITS = 5).
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [4:0]  pred_index;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [4:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] num_branches;
  logic [31:0] num_mispredicts;

  gshare_branch_predictor #(.IDX_BITS(5)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .num_branches(num_branches),
    .num_mispredicts(num_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_val(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [4:0] idx, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_index       = idx;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic check_pred(input string t, input logic [31:0] idx, input logic [31:0] tk,
                            input logic [31:0] tgt);
    expect_val({t, "_index"}, idx);
    expect_val({t, "_taken"}, tk);
    expect_val({t, "_target"}, tgt);
    #1;
    check(32'(pred_index));
    check(32'(pred_taken));
    check(pred_target);
  endtask

  task automatic check_cnt(input string t, input logic [31:0] nb, input logic [31:0] nm);
    expect_val({t, "_num_branches"}, nb);
    expect_val({t, "_num_mispredicts"}, nm);
    #1;
    check(num_branches);
    check(num_mispredicts);
  endtask

  task automatic check_mp(input string t, input logic [31:0] mp);
    expect_val({t, "_mispredict"}, mp);
    #1;
    check(32'(mispredict));
  endtask

  initial begin
    reset = 1'b0; if_pc = 32'h100;
    upd_valid = 1'b0; upd_pc = '0; upd_index = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    tick(); tick();
    reset = 1'b1;

    // Reset state
    check_pred("rst", 32'h0, 32'h0, 32'h104);
    check_cnt("rst", 32'd0, 32'd0);
    check_mp("rst_idle", 32'd0);

    // First taken branch: allocate, mispredict, ghr becomes 1
    upd(32'h100, 5'd0, 1'b1, 32'h80, 1'b0, 32'h104);
    check_mp("alloc", 32'd1);
    tick();
    upd_valid = 1'b0;
    check_cnt("alloc", 32'd1, 32'd1);
    check_mp("idle_after_alloc", 32'd0);
    check_pred("ghr1_pc100", 32'h1, 32'h0, 32'h104);

    // 0x104 folds onto entry 0 with the same tag (aliases); 0x184 differs in tag
    if_pc = 32'h104;
    check_pred("alias_pc104", 32'h0, 32'h1, 32'h80);
    if_pc = 32'h184;
    check_pred("tagmiss_pc184", 32'h0, 32'h0, 32'h188);

    // Reset drops training, then retrain and flush history back to 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    if_pc = 32'h100;
    check_pred("rst2", 32'h0, 32'h0, 32'h104);
    check_cnt("rst2", 32'd0, 32'd0);
    upd(32'h100, 5'd0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    for (int i = 0; i < 5; i++) begin
      upd(32'h200, 5'd3, 1'b0, 32'h0, 1'b0, 32'h204);
      tick();
    end
    upd_valid = 1'b0;
    check_pred("retrain", 32'h0, 32'h1, 32'h80);
    check_cnt("retrain", 32'd6, 32'd1);
    if_pc = 32'h20C;
    check_pred("nt_miss_nowrite", 32'h3, 32'h0, 32'h210);

    // Saturating decrement: 10 -> 01 -> 00 -> 00 -> 00
    if_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 5'd0, 1'b0, 32'h0, 1'b1, 32'h80);
      check_mp($sformatf("dec%0d", i), 32'd1);
      tick();
      upd_valid = 1'b0;
      check_pred($sformatf("dec%0d", i), 32'h0, 32'h0, 32'h104);
    end
    check_cnt("dec", 32'd10, 32'd5);

    // One taken from 00 -> 01: still not taken (ghr=00001)
    upd(32'h100, 5'd0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    upd_valid = 1'b0;
    if_pc = 32'h104;
    check_pred("inc01", 32'h0, 32'h0, 32'h108);

    // Second taken with new target: target-only mispredict, ctr 10 (ghr=00011)
    upd(32'h100, 5'd0, 1'b1, 32'h90, 1'b1, 32'h80);
    check_mp("tgt_mp", 32'd1);
    tick();
    upd_valid = 1'b0;
    if_pc = 32'h10C;
    check_pred("inc10", 32'h0, 32'h1, 32'h90);
    check_cnt("inc10", 32'd12, 32'd7);

    // Same-cycle update and predict: old ctr visible this cycle
    upd(32'h100, 5'd0, 1'b0, 32'h0, 1'b1, 32'h90);
    check_pred("same_cycle_old", 32'h0, 32'h1, 32'h90);
    tick();
    upd_valid = 1'b0;
    if_pc = 32'h118;
    check_pred("same_cycle_new", 32'h0, 32'h0, 32'h11C);
    check_cnt("same_cycle", 32'd13, 32'd8);

    // Correct prediction: no mispredict
    upd(32'h100, 5'd0, 1'b1, 32'h90, 1'b1, 32'h90);
    check_mp("correct", 32'd0);
    tick();
    upd_valid = 1'b0;
    check_cnt("correct", 32'd14, 32'd8);

    // Fall-through wraps at 2^32 (ghr=01101, index 0x12 invalid)
    if_pc = 32'hFFFF_FFFC;
    check_pred("wrap", 32'h12, 32'h0, 32'h0);

    // Reset concurrent with an update: no allocation, history and counters clear
    reset = 1'b0;
    upd(32'h300, 5'd7, 1'b1, 32'h40, 1'b0, 32'h304);
    tick();
    reset = 1'b1;
    upd_valid = 1'b0;
    if_pc = 32'h31C;
    check_pred("rst_upd", 32'h7, 32'h0, 32'h320);
    check_cnt("rst_upd", 32'd0, 32'd0);
    if_pc = 32'h100;
    check_pred("rst_upd_e0", 32'h0, 32'h0, 32'h104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
